// File: rtl/lt24_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words
// and flags whether the running image matches the expected build.
module lt24_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1403259050,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    LAT_ID,
    REQ_TS,
    LAT_TS,
    FINISH
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LMAX =
    (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    lcnt_q, lcnt_d;
  logic          auto_q;
  logic          go, cap_id, cap_ts, set_to;

  assign avm_read    = (state_q == REQ_ID) || (state_q == REQ_TS);
  assign avm_address = (state_q == REQ_TS);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    lcnt_d  = lcnt_q;
    go      = 1'b0;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    set_to  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = REQ_ID;
          go      = 1'b1;
        end
      end
      REQ_ID, REQ_TS: begin
        if (!avm_waitrequest) begin
          tcnt_d = '0;
          lcnt_d = '0;
          if (READ_LATENCY == 0) begin
            cap_id  = (state_q == REQ_ID);
            cap_ts  = (state_q == REQ_TS);
            state_d = (state_q == REQ_ID) ? REQ_TS : FINISH;
          end else begin
            state_d = (state_q == REQ_ID) ? LAT_ID : LAT_TS;
          end
        end else if (tcnt_q == TMAX) begin
          tcnt_d  = '0;
          set_to  = 1'b1;
          state_d = FINISH;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      LAT_ID, LAT_TS: begin
        // data is valid on the last wait cycle only
        if (lcnt_q == LMAX) begin
          lcnt_d  = '0;
          cap_id  = (state_q == LAT_ID);
          cap_ts  = (state_q == LAT_TS);
          state_d = (state_q == LAT_ID) ? REQ_TS : FINISH;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      lcnt_q   <= '0;
      auto_q   <= AUTO_START;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
      auto_q  <= 1'b0;
      if (go) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
      if (set_to) timeout <= 1'b1;
    end
  end

endmodule
